// File: rtl/integration_mult.sv
// integration_mult: registered signed multiplier with a radix-4 Booth core between input and output registers.
// Ports:
//   a, b       - signed N-bit operands, captured on the rising clk edge when en = 1
//   clk        - single clock, rising-edge
//   reset      - asynchronous active-high reset; clears both register stages
//   en         - enable for both pipeline stages; low freezes the pipeline
//   MulXResult - registered signed 2N-bit product, two enabled edges after capture
module integration_mult #(
    parameter int N = 32
) (
    input  logic signed [N-1:0]   a,
    input  logic signed [N-1:0]   b,
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    output logic signed [2*N-1:0] MulXResult
);
    localparam int R = N / 2;

    logic signed [N-1:0] a_q, b_q;
    logic [2*N-1:0] p;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q        <= '0;
            b_q        <= '0;
            MulXResult <= '0;
        end else if (en) begin
            a_q        <= a;
            b_q        <= b;
            MulXResult <= $signed(p);
        end
    end

    // Booth digits come from overlapping bit triplets of b_q with an implied zero below bit 0.
    // Negative digits use one's complement in the row plus a +1 at the row's weight, collected
    // in a separate correction row so no per-row adder is needed.
    always_comb begin
        logic [N:0]     bx;
        logic [2:0]     trip;
        logic           mag1, mag2, neg;
        logic [2*N-1:0] ax, sel, row, nrow, s, c, t;
        bx   = {b_q, 1'b0};
        ax   = {{N{a_q[N-1]}}, a_q};
        nrow = '0;
        s    = '0;
        c    = '0;
        for (int i = 0; i < R; i++) begin
            trip = bx[2*i +: 3];
            mag1 = trip[0] ^ trip[1];
            mag2 = (trip == 3'b011) || (trip == 3'b100);
            neg  = trip[2] & ~(trip[1] & trip[0]);
            sel  = mag2 ? (ax << 1) : (mag1 ? ax : '0);
            row  = (neg ? ~sel : sel) << (2 * i);
            nrow[2*i] = neg;
            // carry-save accumulate: sum and carry vectors stay unresolved until the final add
            t = s ^ c ^ row;
            c = ((s & c) | (s & row) | (c & row)) << 1;
            s = t;
        end
        t = s ^ c ^ nrow;
        c = ((s & c) | (s & nrow) | (c & nrow)) << 1;
        s = t;
        p = s + c;
    end
endmodule

// File: tb/tb_integration_mult.sv
// tb_integration_mult: randomized and directed self-checking bench for integration_mult.
module tb_integration_mult;
    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               en = 1'b1;
    logic signed [31:0] a = '0;
    logic signed [31:0] b = '0;
    logic signed [63:0] MulXResult;
    int checks = 0;
    int errors = 0;
    longint hist[$];
    longint expv;

    integration_mult #(.N(32)) dut (
        .a(a), .b(b), .clk(clk), .reset(reset), .en(en), .MulXResult(MulXResult)
    );

    always #5 clk = ~clk;

    // Reference: the output shows the product of the operands captured two enabled edges ago.
    always @(posedge clk or posedge reset) begin
        if (reset) hist.delete();
        else if (en) begin
            hist.push_back(longint'(a) * longint'(b));
            if (hist.size() > 2) void'(hist.pop_front());
        end
    end

    always_comb expv = (hist.size() == 2) ? hist[0] : 64'sd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) check("model", MulXResult, expv);

    task automatic lit(input logic signed [31:0] x, input logic signed [31:0] y,
                       input logic [63:0] exp, input string name);
        @(negedge clk);
        a = x; b = y; en = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 check(name, MulXResult, exp);
    endtask

    function automatic logic signed [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'sh8000_0000;
            1: return 32'sh7fff_ffff;
            2: return -32'sd1;
            3: return 32'sd0;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1 check("reset_initial", MulXResult, 64'd0);
        repeat (3) begin
            @(negedge clk);
            a = $urandom; b = $urandom;
        end
        #1 check("reset_held", MulXResult, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        a = 32'sd5; b = -32'sd7;
        @(posedge clk);
        #1 check("post_reset_zero", MulXResult, 64'd0);
        @(posedge clk);
        #1 check("mixed_5_m7", MulXResult, -64'sd35);
        lit(-32'sd9, 32'sd5, -64'sd45, "mixed_m9_5");
        lit(32'sd2, 32'sd3, 64'sd6, "same_2_3");
        lit(-32'sd12, -32'sd4, 64'sd48, "same_m12_m4");
        lit(32'sd4, 32'sd6, 64'sd24, "same_4_6");
        lit(-32'sd1, -32'sd7, 64'sd7, "same_m1_m7");
        lit(32'sd11, 32'sd0, 64'sd0, "ident_zero");
        lit(32'sd10, 32'sd1, 64'sd10, "ident_one");
        lit(32'sh8000_0000, 32'sh8000_0000, 64'h4000_0000_0000_0000, "min_min");
        lit(32'sh7fff_ffff, 32'sh8000_0000, 64'hc000_0000_8000_0000, "max_min");
        lit(-32'sd1, -32'sd1, 64'sd1, "m1_m1");
        lit(32'sd7, 32'sd8, 64'sd56, "pre_freeze");
        @(negedge clk);
        en = 1'b0;
        repeat (3) begin
            a = $urandom; b = $urandom;
            @(negedge clk);
        end
        check("frozen", MulXResult, 64'sd56);
        en = 1'b1;
        a = 32'sd3; b = -32'sd3;
        @(posedge clk);
        @(posedge clk);
        #1 check("resume", MulXResult, -64'sd9);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            a = pick(); b = pick();
            en = ($urandom_range(0, 9) < 8);
            if (i == 150) begin
                reset = 1'b1;
                #1 check("reset_midstream", MulXResult, 64'd0);
            end
            if (i == 152) reset = 1'b0;
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
